// File: rtl/cpu_fetch_pkg.sv
// Shared constants for the CPU fetch front end: FSM encodings, instruction
// field positions and RAM control values.
package cpu_fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_ISSUE = 2'd1;
  localparam fetch_state_t ST_WAIT  = 2'd2;

  localparam int COND_MSB   = 31;
  localparam int COND_LSB   = 28;
  localparam int OPCODE_MSB = 27;
  localparam int OPCODE_LSB = 24;

  localparam logic RW_READ = 1'b1;

  // Wide enough for the largest supported RAM latency (4).
  localparam int LAT_W = 3;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO with registered head output; flush empties it and takes
// priority over push and pop in the same cycle.
module fetch_buffer #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] head_reg;
  logic [WIDTH-1:0] tail_reg;
  logic [1:0]       count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == 2'd0);
  assign full    = (count_reg == 2'd2);
  assign count   = count_reg;
  assign rdata   = head_reg;
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= 2'd0;
    end else if (flush) begin
      count_reg <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_reg == 2'd0) head_reg <= wdata;
          else                   tail_reg <= wdata;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          head_reg  <= tail_reg;
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; only the contents shift.
          if (count_reg == 2'd1) begin
            head_reg <= wdata;
          end else begin
            head_reg <= tail_reg;
            tail_reg <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding instruction RAM request FSM, and a
// 2-entry decoder-facing buffer with redirect flush and end-address halt.
module instr_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter int                RAM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] END_ADDR = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              ram_enable,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RAM_LAT);

  fetch_state_t             state_reg;
  logic [ADDR_W-1:0]        pc_reg;
  logic [ADDR_W-1:0]        req_addr_reg;
  logic [LAT_W-1:0]         lat_reg;
  logic                     discard_reg;

  logic                     issue_go;
  logic                     wait_done;
  logic                     buf_push;
  logic [DATA_W+ADDR_W-1:0] buf_rdata;
  logic [1:0]               buf_count;
  logic                     buf_empty;
  logic                     buf_full;

  // A redirect in ISSUE suppresses the request so the old pc is never read.
  assign issue_go  = (state_reg == ST_ISSUE) && !redirect && !buf_full &&
                     (pc_reg != END_ADDR);
  assign wait_done = (state_reg == ST_WAIT) && (lat_reg == LAT_W'(1));
  assign buf_push  = wait_done && !discard_reg && !redirect;

  assign ram_enable = issue_go || (state_reg == ST_WAIT);
  assign ram_rw     = RW_READ;
  assign ram_addr   = issue_go ? pc_reg :
                      (state_reg == ST_WAIT) ? req_addr_reg : '0;

  assign pc          = pc_reg;
  assign instr       = buf_rdata[ADDR_W +: DATA_W];
  assign instr_pc    = buf_rdata[ADDR_W-1:0];
  assign instr_valid = !buf_empty;
  assign halted      = (state_reg == ST_ISSUE) && (pc_reg == END_ADDR) &&
                       (buf_count == 2'd0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= RESET_PC;
      req_addr_reg <= '0;
      lat_reg      <= '0;
      discard_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_reg <= ST_ISSUE;
          if (redirect) pc_reg <= redirect_pc;
        end
        ST_ISSUE: begin
          if (redirect) begin
            pc_reg <= redirect_pc;
          end else if (issue_go) begin
            req_addr_reg <= pc_reg;
            pc_reg       <= pc_reg + 1'b1;
            lat_reg      <= LAT_INIT;
            state_reg    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          lat_reg <= lat_reg - LAT_W'(1);
          if (redirect) pc_reg <= redirect_pc;
          // A redirect on the completing cycle drops the word via buf_push.
          if (wait_done) begin
            discard_reg <= 1'b0;
            state_reg   <= ST_ISSUE;
          end else if (redirect) begin
            discard_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  fetch_buffer #(
    .WIDTH(DATA_W + ADDR_W)
  ) u_buf (
    .clk  (Clk),
    .rst_n(Reset),
    .push (buf_push),
    .wdata({ram_rdata, req_addr_reg}),
    .pop  (instr_ready),
    .flush(redirect),
    .rdata(buf_rdata),
    .count(buf_count),
    .empty(buf_empty),
    .full (buf_full)
  );

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front-end fetch stage of the master CPU. Holds the program counter, drives the instruction RAM read port (Enable / RW / Address), captures the returned word, and presents it to the decoder through a 2-entry buffer with a valid/ready handshake. It supports branch redirect (flush), a stall via back-pressure, and a halt at a programmable end address.

Parameters:
ADDR_W, 16, RAM word-address width
DATA_W, 32, instruction width
RAM_LAT, 1, cycles from Enable/Address presented to Out valid (1..4)
RESET_PC, 0, first fetch address after reset
END_ADDR, 16'hFFFF, address at which fetching stops (this address is not fetched)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
ram_enable  out  1  RAM Enable
ram_rw  out  1  RAM RW; always 1 (read) from this block
ram_addr  out  ADDR_W  RAM Address_in
ram_rdata  in  DATA_W  RAM Out
instr  out  DATA_W  instruction to decoder (Cond=[31:28], OpCode=[27:24])
instr_pc  out  ADDR_W  address of instr
instr_valid  out  1  instr/instr_pc valid
instr_ready  in  1  decoder accepts when valid&ready
redirect  in  1  branch taken; flush and refetch
redirect_pc  in  ADDR_W  branch target
pc  out  ADDR_W  next address to fetch
halted  out  1  pc reached END_ADDR and buffer drained

Behaviour:
- Reset (Reset=0, async): pc=RESET_PC; ram_enable=0; ram_rw=1; ram_addr=0; buffer empty; instr_valid=0; instr=0; instr_pc=0; halted=0; FSM=IDLE; lat counter=0; discard flag=0.
- FSM:
  - IDLE: go to ISSUE the first cycle after reset release.
  - ISSUE: if buffer has a free slot (counting the in-flight word) and pc!=END_ADDR, then ram_enable=1, ram_addr=pc, pc<=pc+1, load lat counter=RAM_LAT, go to WAIT. Otherwise stay, ram_enable=0.
  - WAIT: ram_enable held 1 with the same ram_addr. Decrement counter; when it reaches 0, sample ram_rdata, push {word, addr} into the buffer (unless discard=1), clear discard, go to ISSUE.
- One outstanding request maximum. Best-case throughput is one word per RAM_LAT+1 cycles.
- Buffer: 2-entry FIFO with registered outputs. instr_valid = not empty. Pop on instr_valid&instr_ready. Push and pop in the same cycle with 1 entry held: occupancy stays 1. Push while full is impossible by construction (ISSUE checks space), and the bench must assert this never occurs.
- Empty buffer: a word pushed at edge N appears with instr_valid=1 after edge N. Zero-cycle bypass from ram_rdata is not allowed.
- instr/instr_pc must stay stable while instr_valid=1 and instr_ready=0.
- Redirect (sampled at posedge, highest priority):
  - Buffer is flushed (instr_valid=0 next cycle) and pc<=redirect_pc.
  - If in WAIT, set discard=1; the in-flight word is dropped and the FSM finishes WAIT before re-issuing. Otherwise go straight to ISSUE.
  - Redirect while halted clears halted and resumes fetching.
  - Redirect coinciding with a pop: the pop is ignored (flush wins).
  - Redirect coinciding with a push: the pushed word is dropped.
- Address wrap: pc increments modulo 2^ADDR_W.
- halted=1 when pc==END_ADDR, the FSM is in ISSUE, no request is in flight, and the buffer is empty.
- ram_rw is never driven 0.

Decomposition:
- Package cpu_fetch_pkg holds:
  - FSM state enum {IDLE, ISSUE, WAIT}
  - instruction field slice constants (COND_MSB=31, OPCODE_MSB=27, ...)
  - RW_READ=1
- Sub-module fetch_buffer: 2-deep {DATA_W+ADDR_W} FIFO with push, pop, flush, count, empty, full. The top level holds the FSM, PC and latency counter.

Test Plan:
- Straight-line fetch: RAM[0..3]=32'hE0000001..4, RAM_LAT=1, ready=1 -> instr sequence 0xE0000001..4 with instr_pc 0..3, one word every 2 cycles, ram_rw constantly 1.
- Back-pressure: ready=0 for 10 cycles from start -> exactly 2 words buffered, ram_enable stays 0 after the second fetch, instr held at RAM[0]; release ready -> order preserved, nothing lost.
- Redirect mid-WAIT: RAM_LAT=3, redirect at cycle 2 of fetching addr 1, redirect_pc=8 -> word for addr 1 never presented; next instr_pc=8 with data RAM[8].
- Redirect with a full buffer plus simultaneous pop: -> instr_valid=0 the next cycle, first valid instr_pc = redirect_pc.
- Halt: END_ADDR=4 -> words 0..3 delivered, halted=1 after the last pop, no access to addr 4; redirect to 0 -> halted=0 and refetch RAM[0].
- Async reset mid-WAIT: drop Reset between edges -> outputs go to their reset values immediately; after release the first fetch is at RESET_PC.
